// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit issuing one 64-bit read at a time and presenting {pc, inst} to decode.
// Optional IFU_PERF_EN builds the delivered-instruction and decode-stall counters.
module ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [63:0]       resp_data,
  input  logic              resp_err,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [63:0]       out_inst,
  output logic              out_err,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, out_pc_n;
  logic [63:0] out_inst_n;
  logic flush, flush_n, out_valid_n, out_err_n;
  assign req_valid = rst_n && state == REQ;
  assign req_addr = {pc[ADDR_W-1:3], 3'b0};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      pc <= RESET_PC;
      flush <= 1'b0;
      out_valid <= 1'b0;
      out_pc <= RESET_PC;
      out_inst <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      flush <= flush_n;
      out_valid <= out_valid_n;
      out_pc <= out_pc_n;
      out_inst <= out_inst_n;
      out_err <= out_err_n;
    end
  end
  // A redirect wins over every other event; a request already accepted or still in flight is marked stale via flush.
  always_comb begin
    state_n = state;
    pc_n = pc;
    flush_n = flush;
    out_valid_n = out_valid;
    out_pc_n = out_pc;
    out_inst_n = out_inst;
    out_err_n = out_err;
    if (redirect_vld) begin
      pc_n = redirect_pc;
      out_valid_n = 1'b0;
      state_n = (state == HOLD || (state == WAIT && resp_valid)) ? REQ :
                (state == REQ && req_ready) ? WAIT : state;
      flush_n = ((state == REQ && req_ready) || (state == WAIT && !resp_valid)) ? 1'b1 :
                (state == WAIT) ? 1'b0 : flush;
    end else if (state == REQ && req_ready) begin
      state_n = WAIT;
    end else if (state == WAIT && resp_valid && flush) begin
      flush_n = 1'b0;
      state_n = REQ;
    end else if (state == WAIT && resp_valid) begin
      out_inst_n = {32'b0, pc[2] ? resp_data[63:32] : resp_data[31:0]};
      out_pc_n = pc;
      out_err_n = resp_err || pc[1:0] != 2'b00;
      out_valid_n = 1'b1;
      state_n = HOLD;
    end else if (state == HOLD && out_ready) begin
      pc_n = pc + ADDR_W'(4);
      out_valid_n = 1'b0;
      state_n = REQ;
    end
  end
`ifdef IFU_PERF_EN
  logic [63:0] fetch_cnt, stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready && !redirect_vld) fetch_cnt <= fetch_cnt + 64'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 64'd1;
    end
  end
  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a latency-configurable single-outstanding memory model.
module tb_ifu_fetch;
`ifdef IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 0, rst_n, req_valid, req_ready, resp_valid, resp_err, redirect_vld;
  logic out_valid, out_ready, out_err;
  logic [63:0] req_addr, resp_data, redirect_pc, out_pc, out_inst, perf_fetch_cnt, perf_stall_cnt;
  logic [63:0] mem_data, last_addr;
  logic mem_err, seen_stale = 0;
  int mem_lat, req_cnt, hs = 0, n_cmp = 0, n_err = 0, c;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // memory: answers each accepted request mem_lat cycles later
  initial begin
    int cnt;
    logic acc;
    logic [63:0] a;
    resp_valid = 0; resp_data = 0; resp_err = 0; cnt = 0; req_cnt = 0; last_addr = 0;
    forever begin
      @(posedge clk);
      acc = req_valid && req_ready;
      a = req_addr;
      #1;
      resp_valid = 0;
      if (!rst_n) cnt = 0;
      else if (acc) begin
        req_cnt++;
        last_addr = a;
        cnt = mem_lat - 1;
        if (cnt == 0) begin resp_valid = 1; resp_data = mem_data; resp_err = mem_err; end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin resp_valid = 1; resp_data = mem_data; resp_err = mem_err; end
      end
    end
  end

  always @(posedge clk) if (rst_n && out_valid && out_ready && !redirect_vld) hs++;
  always @(negedge clk) if (out_valid && out_inst[31:0] == 32'hdeadbeef) seen_stale = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_out(output int cyc);
    cyc = 0;
    while (out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    if (!out_valid) chk("out_timeout", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_vld = 1;
    redirect_pc = target;
    @(negedge clk);
    redirect_vld = 0;
  endtask

  initial begin
    rst_n = 0; req_ready = 1; out_ready = 1; redirect_vld = 0; redirect_pc = 0;
    mem_lat = 1; mem_data = 64'h0000_0013_0010_0093; mem_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 0);
    chk("rst_req_valid", {63'b0, req_valid}, 0);
    chk("rst_out_pc", out_pc, 64'h8000_0000);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", {63'b0, out_err}, 0);
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
    rst_n = 1;
    #1;
    chk("first_req_valid", {63'b0, req_valid}, 1);
    chk("first_req_addr", req_addr, 64'h8000_0000);
    next_out(c);
    chk("first_latency", c, 2);
    chk("f0_pc", out_pc, 64'h8000_0000);
    chk("f0_inst", out_inst, 64'h0010_0093);
    chk("f0_err", {63'b0, out_err}, 0);
    chk("f0_addr", last_addr, 64'h8000_0000);
    next_out(c);
    chk("throughput", c, 3);
    chk("f1_pc", out_pc, 64'h8000_0004);
    chk("f1_inst", out_inst, 64'h0000_0013);
    chk("f1_addr", last_addr, 64'h8000_0000);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'b0, out_valid}, 1);
      chk("stall_pc", out_pc, 64'h8000_0004);
      chk("stall_inst", out_inst, 64'h0000_0013);
    end
    chk("stall_cnt", perf_stall_cnt, PERF ? 64'd5 : 64'd0);
    chk("stall_fetch_cnt", perf_fetch_cnt, PERF ? 64'd1 : 64'd0);
    chk("stall_no_req", req_cnt, 2);
    out_ready = 1;
    next_out(c);
    chk("f2_pc", out_pc, 64'h8000_0008);
    chk("f2_inst", out_inst, 64'h0010_0093);
    chk("f2_fetch_cnt", perf_fetch_cnt, PERF ? 64'd2 : 64'd0);
    req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_valid", {63'b0, req_valid}, 1);
      chk("bp_req_addr", req_addr, 64'h8000_0008);
    end
    req_ready = 1;
    next_out(c);
    chk("f3_pc", out_pc, 64'h8000_000c);
    chk("f3_inst", out_inst, 64'h0000_0013);
    chk("bp_one_req", req_cnt, 4);
    mem_lat = 3;
    mem_data = 64'hdead_beef_dead_beef;
    @(negedge clk);
    chk("stale_req", {63'b0, req_valid}, 1);
    @(negedge clk);
    chk("stale_wait", {63'b0, req_valid}, 0);
    redirect(64'h8000_0100);
    @(negedge clk);
    mem_data = 64'h1111_2222_3333_4444;
    mem_lat = 1;
    next_out(c);
    chk("redir_wait_pc", out_pc, 64'h8000_0100);
    chk("redir_wait_inst", out_inst, 64'h3333_4444);
    chk("redir_wait_addr", last_addr, 64'h8000_0100);
    chk("no_stale", {63'b0, seen_stale}, 0);
    redirect(64'h8000_0200);
    chk("redir_hold_valid", {63'b0, out_valid}, 0);
    chk("redir_hold_req", {63'b0, req_valid}, 1);
    chk("redir_hold_addr", req_addr, 64'h8000_0200);
    chk("redir_hold_hs", hs, 4);
    chk("redir_hold_fetch", perf_fetch_cnt, PERF ? 64'd4 : 64'd0);
    next_out(c);
    chk("f200_pc", out_pc, 64'h8000_0200);
    chk("f200_inst", out_inst, 64'h3333_4444);
    mem_err = 1;
    redirect(64'h8000_0008);
    next_out(c);
    chk("err_pc", out_pc, 64'h8000_0008);
    chk("err_flag", {63'b0, out_err}, 1);
    mem_err = 0;
    redirect(64'h8000_0002);
    next_out(c);
    chk("mis_addr", last_addr, 64'h8000_0000);
    chk("mis_pc", out_pc, 64'h8000_0002);
    chk("mis_err", {63'b0, out_err}, 1);
    chk("mis_inst", out_inst, 64'h3333_4444);
    next_out(c);
    chk("mis6_pc", out_pc, 64'h8000_0006);
    chk("mis6_inst", out_inst, 64'h1111_2222);
    chk("mis6_err", {63'b0, out_err}, 1);
    redirect(64'hffff_ffff_ffff_fffc);
    next_out(c);
    chk("top_addr", last_addr, 64'hffff_ffff_ffff_fff8);
    chk("top_pc", out_pc, 64'hffff_ffff_ffff_fffc);
    chk("top_inst", out_inst, 64'h1111_2222);
    chk("top_err", {63'b0, out_err}, 0);
    next_out(c);
    chk("wrap_pc", out_pc, 64'h0);
    chk("wrap_addr", last_addr, 64'h0);
    chk("wrap_inst", out_inst, 64'h3333_4444);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
